// File: rtl/div_pkg.sv
// Shared state encoding and constants for the sequential radix-2 divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    localparam int DIV_DEFAULT_WIDTH = 32;

    // The divide-by-zero quotient is this bit replicated across the whole word.
    localparam logic DIV_ZERO_QUOTIENT_BIT = 1'b1;

    function automatic logic quotient_negative(input logic signed_mode,
                                               input logic dividend_msb,
                                               input logic divisor_msb);
        return signed_mode & (dividend_msb ^ divisor_msb);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract,
// and keep the difference only when it did not borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The remainder is always below the divisor, so the top bit of diff is a clean borrow flag.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, divisor_mag};
        if (diff[WIDTH]) begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider with start/busy/done handshake
// and divide-by-zero reporting; one quotient bit per clock.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_t       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] dividend_q;
    logic             neg_quo;
    logic             neg_rem;
    logic             zero_q;

    logic             dividend_neg;
    logic             divisor_neg;
    logic             divisor_zero;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] lo_fixed;
    logic [WIDTH-1:0] hi_fixed;

    // Magnitudes are taken at latch time; the most-negative value maps onto itself,
    // which is still the correct unsigned magnitude.
    always_comb begin
        dividend_neg = signed_op & dividend[WIDTH-1];
        divisor_neg  = signed_op & divisor[WIDTH-1];
        divisor_zero = (divisor == '0);
        dividend_mag = dividend_neg ? -dividend : dividend;
        divisor_mag  = divisor_neg  ? -divisor  : divisor;
        lo_fixed     = neg_quo ? -quo_q : quo_q;
        hi_fixed     = neg_rem ? -rem_q : rem_q;
    end

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem        (rem_q),
        .quo        (quo_q),
        .divisor_mag(divisor_q),
        .rem_next   (rem_step),
        .quo_next   (quo_step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            dividend_q  <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            zero_q      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rem_q      <= '0;
                        quo_q      <= dividend_mag;
                        divisor_q  <= divisor_mag;
                        dividend_q <= dividend;
                        neg_quo    <= quotient_negative(signed_op, dividend[WIDTH-1],
                                                        divisor[WIDTH-1]);
                        neg_rem    <= dividend_neg;
                        zero_q     <= divisor_zero;
                        count      <= '0;
                        busy       <= 1'b1;
                        state      <= divisor_zero ? FIX : RUN;
                    end
                end
                RUN: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    count <= count + CNT_W'(1);
                    if (count == LAST_ITER) begin
                        busy  <= 1'b0;
                        state <= FIX;
                    end
                end
                FIX: begin
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    div_by_zero <= zero_q;
                    if (zero_q) begin
                        hi <= dividend_q;
                        lo <= {WIDTH{DIV_ZERO_QUOTIENT_BIT}};
                    end else begin
                        hi <= hi_fixed;
                        lo <= lo_fixed;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
